operand_fetch: RTL

Decode-side reader for the 8×16-bit GPR file. Accepts decoded instructions over a valid/ready handshake and drives the register-file read ports. Tracks in-flight destination writes in an 8-entry scoreboard, stalling on RAW/WAW hazards and bypassing same-cycle writeback data. Presents resolved operands to execute through a one-deep output register.

---
 rtl/urisc_pkg.sv | 14 +
 rtl/operand_fetch_scoreboard.sv | 48 ++++
 rtl/operand_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/urisc_pkg.sv
// ============================================================================
// Module      : urisc_pkg
// Description : Shared register-index and data-word types for the uRISC core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package urisc_pkg;
  typedef logic [2:0]  reg_idx_t;
  typedef logic [15:0] word_t;
  localparam int NUM_GPR = 8;
endpackage

`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
// ============================================================================
// Module      : operand_fetch_scoreboard
// Description : Per-GPR pending-write bits with set/clear/flush and hazard query.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_scoreboard
  import urisc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 set_en,
  input  reg_idx_t             set_idx,
  input  logic                 clr_en,
  input  reg_idx_t             clr_idx,
  input  reg_idx_t             q_rs,
  input  reg_idx_t             q_rt,
  input  reg_idx_t             q_rd,
  output logic                 pend_rs,
  output logic                 pend_rt,
  output logic                 pend_rd,
  output logic [NUM_GPR-1:0]   pend
);

  logic [NUM_GPR-1:0] pend_nxt;

  // Clear is applied before set so a same-index set/clear leaves the bit set.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_idx] = 1'b0;
    if (set_en) pend_nxt[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pend <= '0;
    else if (flush) pend <= '0;
    else            pend <= pend_nxt;
  end

  assign pend_rs = pend[q_rs];
  assign pend_rt = pend[q_rt];
  assign pend_rd = pend[q_rd];

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : GPR operand reader with RAW/WAW stall, writeback bypass and
//               a one-deep output register toward execute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
  import urisc_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  reg_idx_t in_rs,
  input  reg_idx_t in_rt,
  input  reg_idx_t in_rd,
  input  logic     in_use_rs,
  input  logic     in_use_rt,
  input  logic     in_wr_rd,
  input  word_t    in_pc,
  output reg_idx_t rf_rs,
  output reg_idx_t rf_rt,
  output logic     rf_en,
  input  word_t    rf_rs_data,
  input  word_t    rf_rt_data,
  input  logic     wb_wr,
  input  reg_idx_t wb_rd,
  input  word_t    wb_data,
  input  logic     flush,
  output logic     out_valid,
  input  logic     out_ready,
  output word_t    out_rs_val,
  output word_t    out_rt_val,
  output reg_idx_t out_rd,
  output logic     out_wr_rd,
  output word_t    out_pc
);

  logic               pend_rs, pend_rt, pend_rd;
  logic [NUM_GPR-1:0] pend;
  logic               byp_rs, byp_rt, byp_rd;
  logic               hazard;
  logic               accept;

  assign rf_rs = in_rs;
  assign rf_rt = in_rt;
  assign rf_en = in_valid;

  assign byp_rs = wb_wr && (wb_rd == in_rs);
  assign byp_rt = wb_wr && (wb_rd == in_rt);
  assign byp_rd = wb_wr && (wb_rd == in_rd);

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  assign hazard = (in_use_rs && pend_rs && !byp_rs) ||
                  (in_use_rt && pend_rt && !byp_rt) ||
                  (in_wr_rd  && pend_rd && !byp_rd);

  assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  operand_fetch_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .set_en  (accept && in_wr_rd),
    .set_idx (in_rd),
    .clr_en  (wb_wr),
    .clr_idx (wb_rd),
    .q_rs    (in_rs),
    .q_rt    (in_rt),
    .q_rd    (in_rd),
    .pend_rs (pend_rs),
    .pend_rt (pend_rt),
    .pend_rd (pend_rd),
    .pend    (pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      out_rd     <= '0;
      out_wr_rd  <= 1'b0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_rs_val <= byp_rs ? wb_data : rf_rs_data;
      out_rt_val <= byp_rt ? wb_data : rf_rt_data;
      out_rd     <= in_rd;
      out_wr_rd  <= in_wr_rd;
      out_pc     <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
